// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: word layout, end marker and FSM states.
package music_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned TONE_MSB = 31;
  localparam int unsigned TONE_LSB = 16;
  localparam int unsigned BEAT_MSB = 15;
  localparam int unsigned BEAT_LSB = 0;
  localparam int unsigned TONE_W   = TONE_MSB - TONE_LSB + 1;
  localparam int unsigned BEAT_W   = BEAT_MSB - BEAT_LSB + 1;

  localparam logic [BEAT_W-1:0] END_BEAT = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [TONE_W-1:0] tone;
    logic [BEAT_W-1:0] beat;
  } note_t;

  function automatic note_t decode_note(input logic [WORD_W-1:0] word);
    note_t n;
    n.tone = word[TONE_MSB:TONE_LSB];
    n.beat = word[BEAT_MSB:BEAT_LSB];
    return n;
  endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat prescaler: one-cycle tick every TICK_DIV clocks, realigned by clr.
module beat_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((TICK_DIV > 1) ? (TICK_DIV - 2) : 0);
  localparam logic SINGLE = (TICK_DIV == 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Tick is registered one count early so it lands exactly TICK_DIV cycles after clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= SINGLE;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= SINGLE | (r_cnt == CNT_PRE);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/note_sequencer.sv
// Plays a song from ROM on a square-wave buzzer: each word gives a tone
// half-period and a beat count; silent gaps separate consecutive notes.
module note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GAP_TICKS  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_en_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  buzzer_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic              r_en;
  logic              r_buzz;
  logic              r_busy;
  logic              r_done;
  logic [TONE_W-1:0] r_tone;
  logic [TONE_W-1:0] r_phase;
  logic [BEAT_W-1:0] r_beat;
  logic [GAP_W-1:0]  r_gap;

  logic  w_tick;
  logic  w_clr;
  note_t w_note;
  logic  w_at_end;
  logic  w_play_last;
  logic  w_gap_last;
  logic  w_note_done;

  assign w_clr  = (r_state == ST_LOAD);
  assign w_note = decode_note(WORD_W'(rom_data_i));

  beat_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // A note finishes at the end of its gap, or at the end of play when gaps are disabled.
  assign w_at_end    = &r_addr;
  assign w_play_last = (r_state == ST_PLAY) && w_tick && (r_beat == BEAT_W'(1));
  assign w_gap_last  = (r_state == ST_GAP)  && w_tick && (r_gap == GAP_W'(1));
  assign w_note_done = (GAP_TICKS == 0) ? w_play_last : w_gap_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_buzz  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tone  <= '0;
      r_phase <= '0;
      r_beat  <= '0;
      r_gap   <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      if (stop_i) begin
        r_state <= ST_IDLE;
        r_buzz  <= 1'b0;
        r_busy  <= 1'b0;
        r_phase <= '0;
      end else if (w_note_done) begin
        r_buzz  <= 1'b0;
        r_phase <= '0;
        // The last address never wraps: it ends the song like an end marker.
        if (!w_at_end) begin
          r_addr  <= r_addr + ADDR_WIDTH'(1);
          r_state <= ST_FETCH;
          r_en    <= 1'b1;
        end else if (loop_i) begin
          r_addr  <= '0;
          r_state <= ST_FETCH;
          r_en    <= 1'b1;
        end else begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (start_i) begin
              r_addr  <= '0;
              r_state <= ST_FETCH;
              r_en    <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          ST_FETCH: begin
            r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            r_buzz <= 1'b0;
            if (w_note.beat == END_BEAT) begin
              if (loop_i) begin
                r_addr  <= '0;
                r_state <= ST_FETCH;
                r_en    <= 1'b1;
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_tone  <= w_note.tone;
              r_phase <= w_note.tone - TONE_W'(1);
              r_beat  <= w_note.beat;
              r_state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (r_tone != '0) begin
              if (r_phase == '0) begin
                r_buzz  <= ~r_buzz;
                r_phase <= r_tone - TONE_W'(1);
              end else begin
                r_phase <= r_phase - TONE_W'(1);
              end
            end
            if (w_tick) begin
              if (w_play_last) begin
                r_state <= ST_GAP;
                r_buzz  <= 1'b0;
                r_phase <= '0;
                r_gap   <= GAP_W'(GAP_TICKS);
              end else begin
                r_beat <= r_beat - BEAT_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (w_tick) begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_buzz  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_addr_o = r_addr;
  assign rom_en_o   = r_en;
  assign buzzer_o   = r_buzz;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a cycle-by-cycle expected trace is
// derived from the song contents and compared against the DUT outputs.
module tb_note_sequencer;

  localparam int unsigned AW = 2;
  localparam int unsigned TD = 4;
  localparam int unsigned GT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          stop_i;
  logic          loop_i;
  logic [AW-1:0] rom_addr_o;
  logic          rom_en_o;
  logic [31:0]   rom_data_i;
  logic          buzzer_o;
  logic          busy_o;
  logic          done_o;

  logic [31:0] rom [4];
  logic [5:0]  exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  note_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .TICK_DIV   (TD),
    .GAP_TICKS  (GT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .loop_i     (loop_i),
    .rom_addr_o (rom_addr_o),
    .rom_en_o   (rom_en_o),
    .rom_data_i (rom_data_i),
    .buzzer_o   (buzzer_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_en_o) rom_data_i <= rom[rom_addr_o];
  end

  function automatic logic [5:0] obs();
    return {rom_addr_o, rom_en_o, buzzer_o, busy_o, done_o};
  endfunction

  task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (addr,en,buzz,busy,done)", tag, o, e);
    end
  endtask

  task automatic push(input int a, input bit en, input bit bz, input bit bsy, input bit dn);
    exp_q.push_back({2'(a), en, bz, bsy, dn});
  endtask

  // Expected output per cycle, starting with the first cycle after start_i is sampled.
  task automatic build_trace(input bit lp, input int limit);
    int a;
    int t;
    int b;
    logic [31:0] w;
    exp_q.delete();
    a = 0;
    forever begin
      if (exp_q.size() >= limit) return;
      push(a, 1, 0, 1, 0);
      push(a, 0, 0, 1, 0);
      w = rom[a];
      t = int'(w[31:16]);
      b = int'(w[15:0]);
      if (b == 0) begin
        if (lp) begin
          a = 0;
          continue;
        end
        push(a, 0, 0, 0, 1);
        return;
      end
      for (int k = 0; k < b * int'(TD); k++)
        push(a, 0, (t != 0) ? 1'((k / t) % 2) : 1'b0, 1, 0);
      for (int k = 0; k < int'(GT * TD); k++)
        push(a, 0, 0, 1, 0);
      if (a == 3) begin
        if (lp) begin
          a = 0;
          continue;
        end
        push(a, 0, 0, 0, 1);
        return;
      end
      a++;
    end
  endtask

  task automatic run_song(input string tag, input bit lp, input int limit, input int ncheck);
    build_trace(lp, limit);
    loop_i  = lp;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < exp_q.size() && i < ncheck; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check(tag, obs(), exp_q[i]);
    end
  endtask

  // After completion DONE holds: address kept, no further done pulse.
  task automatic hold_check(input string tag, input int n);
    logic [5:0] last;
    last = exp_q[exp_q.size() - 1];
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(tag, obs(), {last[5:4], 4'b0000});
    end
  endtask

  task automatic idle_masked(input string tag, input int n);
    logic [5:0] o;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      o = obs();
      check(tag, {2'b00, o[3:0]}, 6'b000000);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    rom = '{32'h0, 32'h0, 32'h0, 32'h0};
    #3;
    check("reset_state", obs(), 6'b000000);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("idle_after_reset", obs(), 6'b000000);
    end

    rom = '{32'h0003_0002, 32'h0000_0000, 32'h0, 32'h0};
    run_song("tone3_beat2", 0, 1000, 1000);
    hold_check("done_hold", 3);

    rom = '{32'h0000_0003, 32'h0000_0000, 32'h0, 32'h0};
    run_song("rest_note", 0, 1000, 1000);
    hold_check("rest_done_hold", 2);

    rom = '{32'h0002_0001, 32'h0000_0000, 32'h0, 32'h0};
    run_song("loop_song", 1, 60, 60);
    stop_i = 1'b1; loop_i = 1'b0;
    @(posedge clk); #1;
    stop_i = 1'b0;
    idle_masked("loop_stopped", 2);

    rom = '{32'h0002_0003, 32'h0000_0000, 32'h0, 32'h0};
    run_song("stop_pre", 0, 1000, 7);
    stop_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    idle_masked("stop_over_start", 1);
    stop_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    idle_masked("stop_stays_idle", 3);

    rom = '{32'h0001_0002, 32'h0000_0000, 32'h0, 32'h0};
    run_song("rst_pre", 0, 1000, 5);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 6'b000000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("idle_after_rst_release", obs(), 6'b000000);
    end
    run_song("replay_after_rst", 0, 1000, 1000);
    hold_check("replay_done_hold", 2);

    rom = '{32'h0001_0001, 32'h0002_0001, 32'h0000_0001, 32'h0003_0001};
    run_song("no_wrap", 0, 1000, 1000);
    hold_check("no_wrap_hold", 4);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++)
        rom[j] = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 3))};
      run_song("random_song", 0, 1000, 1000);
      hold_check("random_done_hold", 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
